// File: rtl/alu_cmd_sequencer_if.sv
// Command, ALU and response signal bundle for alu_cmd_sequencer.
// The slave modport is the sequencer; the master modport is the surrounding system.
interface alu_cmd_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [7:0]  cmd_a;
  logic [7:0]  cmd_b;

  logic [2:0]  alu_op;
  logic [7:0]  alu_dato0;
  logic [7:0]  alu_dato1;
  logic [15:0] alu_resultado;
  logic        alu_banderaA;
  logic        alu_banderaB;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_resultado;
  logic        rsp_banderaA;
  logic        rsp_banderaB;
  logic [2:0]  rsp_op;
  logic        rsp_error;
  logic        busy;

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b,
    input  alu_resultado, alu_banderaA, alu_banderaB,
    input  rsp_ready,
    output cmd_ready,
    output alu_op, alu_dato0, alu_dato1,
    output rsp_valid, rsp_resultado, rsp_banderaA, rsp_banderaB, rsp_op, rsp_error,
    output busy
  );

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b,
    output alu_resultado, alu_banderaA, alu_banderaB,
    output rsp_ready,
    input  cmd_ready,
    input  alu_op, alu_dato0, alu_dato1,
    input  rsp_valid, rsp_resultado, rsp_banderaA, rsp_banderaB, rsp_op, rsp_error,
    input  busy
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Front end for the 8-bit combinational ALU: queues commands, issues one at a time,
// holds operands for SETTLE_CYCLES, then returns the captured result and flags.
module alu_cmd_sequencer #(
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  alu_cmd_sequencer_if.slave   bus
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [AW:0]   DEPTH       = (AW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] RESP  = 2'd2;

  logic [18:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  logic [1:0]    r_state;
  logic [CW-1:0] r_settle;

  logic [2:0]    r_alu_op;
  logic [7:0]    r_alu_dato0;
  logic [7:0]    r_alu_dato1;

  logic [15:0]   r_rsp_resultado;
  logic          r_rsp_banderaA;
  logic          r_rsp_banderaB;
  logic [2:0]    r_rsp_op;
  logic          r_rsp_error;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic [18:0]   w_head;
  logic [2:0]    w_head_op;
  logic [7:0]    w_head_a;
  logic [7:0]    w_head_b;
  logic          w_div0;

  assign w_full    = (r_count == DEPTH);
  assign w_empty   = (r_count == '0);
  assign w_push    = bus.cmd_valid && bus.cmd_ready;
  assign w_pop     = (r_state == IDLE) && !w_empty;
  assign w_head    = r_mem[r_rd_ptr];
  assign w_head_op = w_head[18:16];
  assign w_head_a  = w_head[15:8];
  assign w_head_b  = w_head[7:0];
  assign w_div0    = ((w_head_op == 3'b011) || (w_head_op == 3'b100)) && (w_head_b == 8'h00);

  // Readiness depends only on fullness, so a same-cycle pop never frees a slot early.
  assign bus.cmd_ready     = !w_full && !rst;
  assign bus.rsp_valid     = (r_state == RESP);
  assign bus.busy          = (r_state != IDLE) || !w_empty;
  assign bus.alu_op        = r_alu_op;
  assign bus.alu_dato0     = r_alu_dato0;
  assign bus.alu_dato1     = r_alu_dato1;
  assign bus.rsp_resultado = r_rsp_resultado;
  assign bus.rsp_banderaA  = r_rsp_banderaA;
  assign bus.rsp_banderaB  = r_rsp_banderaB;
  assign bus.rsp_op        = r_rsp_op;
  assign bus.rsp_error     = r_rsp_error;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {bus.cmd_op, bus.cmd_a, bus.cmd_b};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= IDLE;
      r_settle        <= '0;
      r_alu_op        <= '0;
      r_alu_dato0     <= '0;
      r_alu_dato1     <= '0;
      r_rsp_resultado <= '0;
      r_rsp_banderaA  <= 1'b0;
      r_rsp_banderaB  <= 1'b0;
      r_rsp_op        <= '0;
      r_rsp_error     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            // Zero divisor is answered locally; the ALU keeps its previous operands.
            if (w_div0) begin
              r_rsp_op        <= w_head_op;
              r_rsp_error     <= 1'b1;
              r_rsp_resultado <= '0;
              r_rsp_banderaA  <= 1'b0;
              r_rsp_banderaB  <= 1'b0;
              r_state         <= RESP;
            end else begin
              r_alu_op    <= w_head_op;
              r_alu_dato0 <= w_head_a;
              r_alu_dato1 <= w_head_b;
              r_settle    <= '0;
              r_state     <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (r_settle == SETTLE_LAST) begin
            r_rsp_resultado <= bus.alu_resultado;
            r_rsp_banderaA  <= bus.alu_banderaA;
            r_rsp_banderaB  <= bus.alu_banderaB;
            r_rsp_op        <= r_alu_op;
            r_rsp_error     <= 1'b0;
            r_state         <= RESP;
          end else begin
            r_settle <= r_settle + CW'(1);
          end
        end
        RESP: begin
          if (bus.rsp_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer with a behavioural ALU in the loop that
// returns corrupted data until its inputs have been stable for SETTLE cycles.
module tb_alu_cmd_sequencer;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned SETTLE = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  alu_cmd_sequencer_if bus ();

  alu_cmd_sequencer #(
    .FIFO_DEPTH   (DEPTH),
    .SETTLE_CYCLES(SETTLE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [2:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] res;
    logic        fa;
    logic        fb;
    logic        err;
    int unsigned acc_cyc;
    bit          fresh;
  } exp_t;

  exp_t        sb [$];
  logic [15:0] rsp_log [$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned n_acc = 0;
  int unsigned n_rsp = 0;
  int unsigned cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // ALU behaviour: {result, flagA = result exceeds 8 bits, flagB = result is zero}
  function automatic logic [17:0] alu_fn(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] r;
    case (op)
      3'd0:    r = {8'd0, a} + {8'd0, b};
      3'd1:    r = {8'd0, a} - {8'd0, b};
      3'd2:    r = {8'd0, a} * {8'd0, b};
      3'd3:    r = (b == 8'd0) ? 16'hFFFF : {8'd0, a / b};
      3'd4:    r = (b == 8'd0) ? 16'hFFFF : {8'd0, a % b};
      3'd5:    r = {8'd0, a & b};
      3'd6:    r = {8'd0, a | b};
      default: r = {8'd0, a ^ b};
    endcase
    return {r, (r[15:8] != 8'd0), (r == 16'd0)};
  endfunction

  function automatic exp_t ref_rsp(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    logic [17:0] f;
    e.op = op; e.a = a; e.b = b;
    e.acc_cyc = 0; e.fresh = 1'b0;
    if ((op == 3'd3 || op == 3'd4) && b == 8'd0) begin
      e.res = 16'd0; e.fa = 1'b0; e.fb = 1'b0; e.err = 1'b1;
    end else begin
      f = alu_fn(op, a, b);
      e.res = f[17:2]; e.fa = f[1]; e.fb = f[0]; e.err = 1'b0;
    end
    return e;
  endfunction

  logic [18:0] alu_prev = '0;
  int unsigned held     = 0;
  logic [17:0] alu_f;

  always @(negedge clk) begin
    if ({bus.alu_op, bus.alu_dato0, bus.alu_dato1} !== alu_prev) begin
      alu_prev <= {bus.alu_op, bus.alu_dato0, bus.alu_dato1};
      held     <= 1;
    end else if (held < 100) begin
      held <= held + 1;
    end
  end

  always_comb begin
    alu_f = alu_fn(bus.alu_op, bus.alu_dato0, bus.alu_dato1);
    if (held >= SETTLE) begin
      bus.alu_resultado = alu_f[17:2];
      bus.alu_banderaA  = alu_f[1];
      bus.alu_banderaB  = alu_f[0];
    end else begin
      bus.alu_resultado = ~alu_f[17:2];
      bus.alu_banderaA  = ~alu_f[1];
      bus.alu_banderaB  = ~alu_f[0];
    end
  end

  logic        prev_valid = 1'b0;
  logic [15:0] hv_res;
  logic        hv_fa, hv_fb, hv_err;
  logic [2:0]  hv_op;
  logic [18:0] last_iss = '0;
  logic [15:0] last_res = '0;
  logic        last_fa = 1'b0, last_err = 1'b0;
  exp_t        hd;
  exp_t        ne;

  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      prev_valid = 1'b0;
      last_iss   = '0;
    end else begin
      if (bus.rsp_valid) begin
        if (!prev_valid) begin
          n_rsp++;
          hv_res = bus.rsp_resultado; hv_fa = bus.rsp_banderaA; hv_fb = bus.rsp_banderaB;
          hv_op  = bus.rsp_op;        hv_err = bus.rsp_error;
          last_res = bus.rsp_resultado; last_fa = bus.rsp_banderaA; last_err = bus.rsp_error;
          rsp_log.push_back(bus.rsp_resultado);
          if (sb.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL rsp_unexpected: got response op %0h with no command outstanding", bus.rsp_op);
          end else begin
            hd = sb[0];
            check("rsp_op",        bus.rsp_op, hd.op);
            check("rsp_error",     bus.rsp_error, hd.err);
            check("rsp_resultado", bus.rsp_resultado, hd.res);
            check("rsp_flags",     {bus.rsp_banderaA, bus.rsp_banderaB}, {hd.fa, hd.fb});
            if (hd.fresh) check("latency", cyc - hd.acc_cyc, hd.err ? 2 : 2 + SETTLE);
            if (hd.err) begin
              check("alu_retained", {bus.alu_op, bus.alu_dato0, bus.alu_dato1}, last_iss);
            end else begin
              check("alu_issued", {bus.alu_op, bus.alu_dato0, bus.alu_dato1}, {hd.op, hd.a, hd.b});
              last_iss = {hd.op, hd.a, hd.b};
            end
          end
        end else begin
          check("rsp_stable", {bus.rsp_resultado, bus.rsp_banderaA, bus.rsp_banderaB, bus.rsp_op, bus.rsp_error},
                {hv_res, hv_fa, hv_fb, hv_op, hv_err});
        end
        if (bus.rsp_ready) begin
          if (sb.size() != 0) void'(sb.pop_front());
          prev_valid = 1'b0;
        end else begin
          prev_valid = 1'b1;
        end
      end else begin
        prev_valid = 1'b0;
      end
      if (bus.cmd_valid && bus.cmd_ready) begin
        ne = ref_rsp(bus.cmd_op, bus.cmd_a, bus.cmd_b);
        ne.acc_cyc = cyc;
        ne.fresh   = !bus.busy;
        sb.push_back(ne);
        n_acc++;
      end
    end
  end

  task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                      input int unsigned max_wait, output bit ok);
    bus.cmd_op = op; bus.cmd_a = a; bus.cmd_b = b; bus.cmd_valid = 1'b1;
    ok = 1'b0;
    for (int unsigned i = 0; i < max_wait && !ok; i++) begin
      @(negedge clk);
      if (bus.cmd_ready) ok = 1'b1;
      @(posedge clk); #1;
    end
    bus.cmd_valid = 1'b0;
  endtask

  task automatic send_chk(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    bit ok;
    send(op, a, b, 50, ok);
    check("cmd_accept", ok, 1);
  endtask

  task automatic wait_drain(input int unsigned max_wait);
    bit done = 1'b0;
    for (int unsigned i = 0; i < max_wait && !done; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !bus.busy && !bus.rsp_valid) done = 1'b1;
    end
    check("drain", done, 1);
    @(posedge clk); #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cmd_ready"}, bus.cmd_ready, 0);
    check({tag, "_rsp_valid"}, bus.rsp_valid, 0);
    check({tag, "_busy"},      bus.busy, 0);
    check({tag, "_alu"},       {bus.alu_op, bus.alu_dato0, bus.alu_dato1}, 0);
    check({tag, "_rsp"},       {bus.rsp_resultado, bus.rsp_banderaA, bus.rsp_banderaB, bus.rsp_op, bus.rsp_error}, 0);
  endtask

  bit          rnd_on = 1'b0;
  bit          ok;
  bit          seen;
  int unsigned base;
  int unsigned acc0;
  int unsigned rsp0;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_a = '0; bus.cmd_b = '0;
    bus.rsp_ready = 1'b0;
    #1 rst = 1'b1;
    #1 check_all_zero("reset");
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_reset_cmd_ready", bus.cmd_ready, 1);
    @(posedge clk); #1;

    // SUM with ALU in loop, then div-by-zero trap and a following RES
    bus.rsp_ready = 1'b1;
    send_chk(3'd0, 8'd200, 8'd100);
    wait_drain(40);
    check("sum_res", last_res, 16'h012C);
    check("sum_fa",  last_fa, 1);
    send_chk(3'd3, 8'd9, 8'd0);
    wait_drain(40);
    check("div0_err", last_err, 1);
    check("div0_res", last_res, 16'h0000);
    send_chk(3'd1, 8'd5, 8'd5);
    wait_drain(40);
    check("res_res", last_res, 16'h0000);
    check("res_err", last_err, 0);

    // Back-pressure: FIFO_DEPTH queued plus one in flight
    bus.rsp_ready = 1'b0;
    acc0 = n_acc;
    base = rsp_log.size();
    send_chk(3'd5, 8'hF0, 8'h3C);
    send_chk(3'd6, 8'hF0, 8'h3C);
    send_chk(3'd7, 8'hF0, 8'h3C);
    send_chk(3'd0, 8'd1, 8'd2);
    send_chk(3'd2, 8'd3, 8'd4);
    send(3'd1, 8'd9, 8'd1, 8, ok);
    check("sixth_rejected", ok, 0);
    send(3'd1, 8'd9, 8'd2, 2, ok);
    check("seventh_rejected", ok, 0);
    check("accepted_count", n_acc - acc0, 5);
    @(negedge clk);
    check("full_cmd_ready", bus.cmd_ready, 0);
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    wait_drain(200);
    check("bp_rsp_count", rsp_log.size() - base, 5);
    if (rsp_log.size() >= base + 3) begin
      check("bp_and", rsp_log[base],     16'h0030);
      check("bp_or",  rsp_log[base + 1], 16'h00FC);
      check("bp_xor", rsp_log[base + 2], 16'h00CC);
    end

    // Response held stable under back-pressure, single-cycle ready pulse
    bus.rsp_ready = 1'b0;
    send_chk(3'd2, 8'd15, 8'd17);
    seen = 1'b0;
    for (int unsigned i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) seen = 1'b1;
    end
    check("pro_rsp_seen", seen, 1);
    repeat (10) begin
      @(negedge clk);
      check("hold_valid", bus.rsp_valid, 1);
      check("hold_res",   bus.rsp_resultado, 16'h00FF);
    end
    @(posedge clk); #1 bus.rsp_ready = 1'b1;
    @(posedge clk); #1 bus.rsp_ready = 1'b0;
    @(negedge clk);
    check("valid_drop", bus.rsp_valid, 0);
    @(posedge clk); #1;
    wait_drain(20);

    // Reset while the first command is settling and three more are queued
    bus.rsp_ready = 1'b1;
    send_chk(3'd0, 8'd11, 8'd22);
    send_chk(3'd1, 8'd33, 8'd4);
    send_chk(3'd6, 8'h0F, 8'h50);
    send_chk(3'd2, 8'd7, 8'd8);
    check("pre_reset_busy", bus.busy, 1);
    rsp0 = n_rsp;
    #2 rst = 1'b1;
    #1 check_all_zero("midreset");
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("release_cmd_ready", bus.cmd_ready, 1);
    repeat (20) @(negedge clk);
    check("no_rsp_after_reset", n_rsp - rsp0, 0);
    check("idle_after_reset", bus.busy, 0);
    @(posedge clk); #1;

    // Pointer wrap: twelve commands, one per response
    base = rsp_log.size();
    for (int unsigned i = 0; i < 12; i++) begin
      send_chk(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom_range(1, 255)));
      wait_drain(40);
    end
    check("wrap_rsp_count", rsp_log.size() - base, 12);
    check("wrap_busy", bus.busy, 0);

    // Random traffic with random response back-pressure
    rnd_on = 1'b1;
    fork
      while (rnd_on) begin
        @(posedge clk); #1;
        if (rnd_on) bus.rsp_ready = ($urandom_range(0, 3) != 0);
      end
    join_none
    for (int unsigned i = 0; i < 60; i++) begin
      send_chk(3'($urandom_range(0, 7)), 8'($urandom),
               ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end
    rnd_on = 1'b0;
    @(posedge clk); #2;
    bus.rsp_ready = 1'b1;
    wait_drain(400);
    check("final_busy", bus.busy, 0);
    check("final_sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Initiator-side front end for the 8-bit combinational ALU (opcode 3 bits, operands 8 bits, 16-bit result, flags A/B).
- Accepts operation commands over a valid/ready handshake and buffers them in a small FIFO.
- Issues one command at a time to the ALU and holds the operands for a programmable settle time.
- Captures result and flags, and returns them over a valid/ready response handshake. Divide/modulo by zero is trapped before issue.

Parameters:
FIFO_DEPTH, 4, command FIFO entries; power of two, ≥2
SETTLE_CYCLES, 1, cycles ALU inputs are held before result capture; ≥1

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready
cmd_op  in  3  opcode: 000 SUM, 001 RES, 010 PRO, 011 DIV, 100 MOD, 101 AND, 110 OR, 111 XOR
cmd_a  in  8  operand 0
cmd_b  in  8  operand 1
alu_op  out  3  registered opcode to ALU
alu_dato0  out  8  registered operand 0 to ALU
alu_dato1  out  8  registered operand 1 to ALU
alu_resultado  in  16  ALU result
alu_banderaA  in  1  ALU flag A
alu_banderaB  in  1  ALU flag B
rsp_valid  out  1  response available
rsp_ready  in  1  response consumed when rsp_valid&&rsp_ready
rsp_resultado  out  16  captured result
rsp_banderaA  out  1  captured flag A
rsp_banderaB  out  1  captured flag B
rsp_op  out  3  opcode of this response
rsp_error  out  1  1 = DIV/MOD with operand 1 == 0, not issued
busy  out  1  FSM not IDLE or FIFO non-empty

Behaviour:
- Reset (async, rst=1): FIFO empty, pointers/count 0, FSM IDLE, settle counter 0. All outputs 0, including cmd_ready and rsp_valid. cmd_ready = !full && !rst.
- FIFO: push on cmd handshake, pop only by FSM in IDLE. No bypass; a command always spends ≥1 cycle in the FIFO. No push while full, even if a pop occurs the same cycle. Pointers wrap modulo FIFO_DEPTH. Strict in-order.
- IDLE:
  - FIFO non-empty: pop head.
  - Head op ∈ {011, 100} and b == 0: load rsp_op, rsp_error=1, rsp_resultado=0, both rsp flags=0, go RESP. alu_* outputs unchanged.
  - Otherwise: load alu_op/alu_dato0/alu_dato1, settle counter 0, go ISSUE.
- ISSUE: counter increments each cycle. In the cycle where counter == SETTLE_CYCLES-1:
  - Register alu_resultado, alu_banderaA, alu_banderaB into rsp_*.
  - Set rsp_op = alu_op, rsp_error=0, go RESP.
- RESP: rsp_valid=1. All rsp_* held stable until handshake. On rsp_ready, next cycle rsp_valid=0 and FSM is IDLE. Pop happens the following cycle, so there are no back-to-back responses.
- alu_* outputs hold their last issued values through RESP/IDLE until the next issue.
- Latency, command accepted in cycle C with FIFO empty and FSM IDLE:
  - Normal: pop in C+1, rsp_valid first high in C+2+SETTLE_CYCLES.
  - Error path: rsp_valid first high in C+2.
- Capacity: FIFO_DEPTH queued plus 1 in flight, i.e. FIFO_DEPTH+1 commands accepted with rsp_ready held 0.
- Reset mid-operation: queued and in-flight commands are discarded. No response is produced for them.
- No arithmetic is performed locally. Only the zero check on operand 1 for DIV/MOD.

Test Plan:
- SUM a=200, b=100, SETTLE=1, real ALU in loop, rsp_ready=1 → rsp_valid in C+3, rsp_resultado=16'h012C, banderaA=1, banderaB=0, rsp_error=0, rsp_op=000.
- DIV a=9, b=0 → rsp_valid in C+2, rsp_error=1, rsp_resultado=0, flags 0. alu_op/alu_dato* retain the prior command's values. A following RES a=5, b=5 → resultado 0, rsp_error=0.
- Back-pressure: rsp_ready=0, offer 7 commands back-to-back → exactly 5 accepted (4 FIFO + 1 in RESP), cmd_ready=0 afterwards. Release rsp_ready → 5 responses in issue order: AND/OR/XOR of 8'hF0, 8'h3C give 16'h0030, 16'h00FC, 16'h00CC.
- Response stability: hold rsp_ready=0 for 10 cycles during a PRO 15×17 response → rsp_resultado=16'h00FF and rsp_valid stay constant throughout. A single rsp_ready pulse → rsp_valid drops next cycle.
- Reset mid-ISSUE with 3 commands queued (SETTLE_CYCLES=4) → all outputs 0 asynchronously. No responses after release. cmd_ready=1 on the first cycle after rst deasserts.
- FIFO wrap: 12 commands fed one per response with rsp_ready=1 → all 12 results in order, pointers wrapped 3 times, busy=0 after the last handshake.
